// File: rtl/snake_body.sv
// Snake body register file: holds head-first cell list, advances it on each tick,
// handles growth, wrap-around and self-collision, and runs the IDLE/RUN/DEAD game FSM.
module snake_body #(
   parameter int max_len         = 16,
   parameter int num_len         = 10,
   parameter int max_len_bit_len = 4,
   parameter int width           = 32,
   parameter int height          = 24,
   parameter int start_x         = 16,
   parameter int start_y         = 12
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         tick,
   input  logic [1:0]                   dir_in,
   input  logic                         grow,
   output logic [max_len*num_len-1:0]   snake,
   output logic [num_len-1:0]           snake_head,
   output logic [max_len_bit_len-1:0]   len,
   output logic                         running,
   output logic                         dead
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

   localparam logic [num_len-1:0]         NONE       = '1;
   localparam logic [num_len-1:0]         ONE_C      = num_len'(1);
   localparam logic [num_len-1:0]         W_C        = num_len'(width);
   localparam logic [num_len-1:0]         H_C        = num_len'(height);
   localparam logic [num_len-1:0]         START_CELL = num_len'(start_y * width + start_x);
   localparam logic [max_len_bit_len-1:0] LEN_INIT   = max_len_bit_len'(2);
   localparam logic [max_len_bit_len-1:0] LEN_ONE    = max_len_bit_len'(1);
   localparam logic [max_len_bit_len-1:0] LEN_MAX    = max_len_bit_len'(max_len - 1);
   localparam logic [1:0]                 DIR_RIGHT  = 2'd3;

   state_t                     state_q, state_d;
   logic [num_len-1:0]         body_q [max_len];
   logic [num_len-1:0]         body_d [max_len];
   logic [max_len_bit_len-1:0] len_q, len_d;
   logic [1:0]                 dir_q, dir_d;
   logic [1:0]                 pdir_q, pdir_d;
   logic                       gpend_q, gpend_d;

   logic [num_len-1:0] hx, hy, nx, ny, new_head;
   logic               do_move, grow_ok, hit;

   // Three-cell horizontal snake ending at the start cell, facing right.
   function automatic logic [num_len-1:0] init_slot(input int i);
      if (i < 3) return START_CELL - num_len'(i);
      return NONE;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (do_move && hit) state_d = S_DEAD;
         S_DEAD:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      running = (state_q == S_RUN);
      dead    = (state_q == S_DEAD);
   end

   // Next head from the pending direction, wrapping at every grid edge.
   always_comb begin
      hx = body_q[0] % W_C;
      hy = body_q[0] / W_C;
      nx = hx;
      ny = hy;
      case (pdir_q)
         2'd0:    ny = (hy == '0) ? H_C - ONE_C : hy - ONE_C;
         2'd1:    ny = (hy == H_C - ONE_C) ? '0 : hy + ONE_C;
         2'd2:    nx = (hx == '0) ? W_C - ONE_C : hx - ONE_C;
         default: nx = (hx == W_C - ONE_C) ? '0 : hx + ONE_C;
      endcase
      new_head = ny * W_C + nx;
   end

   assign do_move = (state_q == S_RUN) && tick;
   assign grow_ok = (gpend_q || grow) && (len_q < LEN_MAX);

   // The departing tail (slot len) only blocks the head when the snake is growing.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < max_len; i++) begin
         if ((i < int'(len_q) || (grow_ok && i == int'(len_q))) && body_q[i] == new_head)
            hit = 1'b1;
      end
   end

   always_comb begin
      body_d  = body_q;
      len_d   = len_q;
      dir_d   = dir_q;
      gpend_d = gpend_q;
      pdir_d  = (dir_in == (dir_q ^ 2'd1)) ? pdir_q : dir_in;
      if (state_q == S_RUN) begin
         if (do_move) begin
            dir_d   = pdir_q;
            gpend_d = 1'b0;
            if (!hit) begin
               for (int i = 1; i < max_len; i++) begin
                  if (i <= int'(len_q) + int'(grow_ok)) body_d[i] = body_q[i-1];
               end
               body_d[0] = new_head;
               len_d     = grow_ok ? len_q + LEN_ONE : len_q;
            end
         end else begin
            gpend_d = gpend_q | grow;
         end
      end else if (state_q == S_DEAD && start) begin
         for (int i = 0; i < max_len; i++) body_d[i] = init_slot(i);
         len_d   = LEN_INIT;
         dir_d   = DIR_RIGHT;
         pdir_d  = DIR_RIGHT;
         gpend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < max_len; i++) body_q[i] <= init_slot(i);
         len_q   <= LEN_INIT;
         dir_q   <= DIR_RIGHT;
         pdir_q  <= DIR_RIGHT;
         gpend_q <= 1'b0;
      end else begin
         body_q  <= body_d;
         len_q   <= len_d;
         dir_q   <= dir_d;
         pdir_q  <= pdir_d;
         gpend_q <= gpend_d;
      end
   end

   for (genvar g = 0; g < max_len; g++) begin : g_pack
      assign snake[g*num_len +: num_len] = body_q[g];
   end

   assign snake_head = body_q[0];
   assign len        = len_q;

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: queue-based game model compared every cycle, plus
// hand-computed scenarios (wrap, reverse, growth, collision, reset).
module tb_snake_body;

   localparam int ML = 16;
   localparam int NL = 10;
   localparam int GW = 32;
   localparam int GH = 24;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              tick = 1'b0;
   logic [1:0]        dir_in = 2'd3;
   logic              grow = 1'b0;
   logic [ML*NL-1:0]  snake;
   logic [NL-1:0]     snake_head;
   logic [3:0]        len;
   logic              running;
   logic              dead;

   snake_body #(.max_len(ML), .num_len(NL), .max_len_bit_len(4), .width(GW),
                .height(GH), .start_x(16), .start_y(12)) dut (
      .clk(clk), .rst(rst), .start(start), .tick(tick), .dir_in(dir_in),
      .grow(grow), .snake(snake), .snake_head(snake_head), .len(len),
      .running(running), .dead(dead));

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [ML*NL-1:0] act, input logic [ML*NL-1:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic int slot(input int i);
      return int'(snake[i*NL +: NL]);
   endfunction

   // ---------------- behavioural model ----------------
   int m_state;      // 0 idle, 1 run, 2 dead
   int body[$];      // head first
   int m_dir, m_pdir, m_gp;

   function automatic int rev(input int d);
      case (d)
         0: return 1;
         1: return 0;
         2: return 3;
         default: return 2;
      endcase
   endfunction

   task automatic model_layout();
      body = '{400, 399, 398};
      m_dir = 3;
      m_gp  = 0;
   endtask

   always @(posedge clk or posedge rst) begin : mdl
      int npd, x, y, nh, lim, can, hitm;
      if (rst) begin
         model_layout();
         m_pdir  = 3;
         m_state = 0;
      end else begin
         npd = (int'(dir_in) == rev(m_dir)) ? m_pdir : int'(dir_in);
         case (m_state)
            0: if (start) m_state = 1;
            1: begin
               if (tick) begin
                  x = body[0] % GW;
                  y = body[0] / GW;
                  case (m_pdir)
                     0: y = (y + GH - 1) % GH;
                     1: y = (y + 1) % GH;
                     2: x = (x + GW - 1) % GW;
                     default: x = (x + 1) % GW;
                  endcase
                  nh  = y * GW + x;
                  can = ((m_gp != 0 || grow) && body.size() < ML) ? 1 : 0;
                  lim = can ? body.size() : body.size() - 1;
                  hitm = 0;
                  for (int k = 0; k < lim; k++) if (body[k] == nh) hitm = 1;
                  m_dir = m_pdir;
                  m_gp  = 0;
                  if (hitm) m_state = 2;
                  else begin
                     body.push_front(nh);
                     if (!can) void'(body.pop_back());
                  end
               end else if (grow) m_gp = 1;
            end
            default: if (start) begin
               model_layout();
               m_state = 1;
               npd = 3;
            end
         endcase
         m_pdir = npd;
      end
   end

   always @(negedge clk) begin
      logic [ML*NL-1:0] ev;
      if (chk_en) begin
         for (int i = 0; i < ML; i++)
            ev[i*NL +: NL] = (i < body.size()) ? NL'(body[i]) : {NL{1'b1}};
         chk("snake", snake, ev);
         chk("head", snake_head, body[0]);
         chk("len", len, body.size() - 1);
         chk("running", running, m_state == 1);
         chk("dead", dead, m_state == 2);
      end
   end

   // ---------------- stimulus ----------------
   // Called just after a posedge; applies inputs for one edge and returns just after it.
   task automatic step(input bit t, input bit g, input logic [1:0] d);
      dir_in = d;
      tick   = t;
      grow   = g;
      @(posedge clk);
      #2;
      tick = 1'b0;
      grow = 1'b0;
   endtask

   task automatic fresh();
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst    = 1'b0;
      start  = 1'b1;
      dir_in = 2'd3;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_head", snake_head, 400);
      chk("rst_slot1", slot(1), 399);
      chk("rst_slot2", slot(2), 398);
      chk("rst_slot3", slot(3), 1023);
      chk("rst_len", len, 2);
      chk("rst_run", running, 0);
      chk("rst_dead", dead, 0);
      chk_en = 1'b1;
      @(posedge clk);
      #2;

      // start then a rightward move
      fresh();
      step(1, 0, 3);
      chk("mv_head", snake_head, 401);
      chk("mv_slot1", slot(1), 400);
      chk("mv_slot2", slot(2), 399);
      chk("mv_slot3", slot(3), 1023);
      chk("mv_len", len, 2);

      // reverse request discarded, then a turn up
      fresh();
      step(0, 0, 2);
      step(1, 0, 2);
      chk("rev_head", snake_head, 401);
      step(0, 0, 0);
      step(1, 0, 0);
      chk("up_head", snake_head, 369);

      // horizontal and vertical wrap
      fresh();
      for (int i = 0; i < 15; i++) step(1, 0, 3);
      chk("edge_head", snake_head, 415);
      step(1, 0, 3);
      chk("wrap_x", snake_head, 384);
      fresh();
      step(0, 0, 0);
      for (int i = 0; i < 12; i++) step(1, 0, 0);
      chk("top_head", snake_head, 16);
      step(1, 0, 0);
      chk("wrap_y", snake_head, 752);

      // growth and saturation
      fresh();
      step(1, 1, 3);
      chk("grow_len", len, 3);
      chk("grow_tail", slot(3), 398);
      for (int i = 0; i < 13; i++) step(1, 1, 3);
      chk("sat_len", len, 15);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 3);
         chk("sat_len_hold", len, 15);
         n_tot++;
         if (slot(15) != 1023) n_pass++;
         else $display("FAIL slot15_none: got %0d expected not 1023", slot(15));
      end

      // pending grow latched without a tick, applied on the next tick
      fresh();
      step(0, 1, 3);
      step(0, 0, 3);
      step(1, 0, 3);
      chk("pend_grow_len", len, 3);

      // five-slot snake turns into its own neck
      fresh();
      step(1, 1, 3);
      step(1, 1, 3);
      step(0, 0, 0);
      step(1, 0, 0);
      step(0, 0, 2);
      step(1, 0, 2);
      step(0, 0, 1);
      step(1, 0, 1);
      chk("col_dead", dead, 1);
      chk("col_run", running, 0);
      chk("col_head", snake_head, 369);
      chk("col_len", len, 4);
      step(1, 1, 1);
      chk("dead_frozen", snake_head, 369);
      dir_in = 2'd3;
      start  = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      chk("restart_run", running, 1);
      chk("restart_head", snake_head, 400);
      chk("restart_slot2", slot(2), 398);
      chk("restart_slot3", slot(3), 1023);
      chk("restart_len", len, 2);

      // head chases into the cell the tail is vacating
      fresh();
      step(1, 1, 3);
      step(0, 0, 0);
      step(1, 0, 0);
      step(0, 0, 2);
      step(1, 0, 2);
      step(0, 0, 1);
      step(1, 0, 1);
      chk("chase_head", snake_head, 400);
      chk("chase_run", running, 1);
      step(1, 0, 1);
      chk("chase_next", snake_head, 432);
      rst = 1'b1;
      #1;
      chk("arst_head", snake_head, 400);
      chk("arst_slot1", slot(1), 399);
      chk("arst_slot3", slot(3), 1023);
      chk("arst_len", len, 2);
      chk("arst_run", running, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // randomized play
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom % 300 == 0);
         start = ($urandom % 25 == 0);
         step($urandom % 3 == 0, $urandom % 5 == 0, 2'($urandom % 4));
      end
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #2;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 SHALL have parameter max_len, default 16, number of body slots.
REQ-002 SHALL have parameter num_len, default 10, bits per position.
REQ-003 SHALL have parameter max_len_bit_len, default 4, width of the length output.
REQ-004 SHALL have parameter width, default 32, grid columns.
REQ-005 SHALL have parameter height, default 24, grid rows.
REQ-006 SHALL have parameters start_x, default 16, and start_y, default 12, giving the initial head cell.
REQ-007 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1, level; launches a game from IDLE or DEAD.
REQ-010 SHALL have port tick, input, 1, single-cycle move strobe.
REQ-011 SHALL have port dir_in, input, 2, requested direction: 0 up, 1 down, 2 left, 3 right.
REQ-012 SHALL have port grow, input, 1, single-cycle pulse from the food/score stage.
REQ-013 SHALL have port snake, output, max_len*num_len; slot i is at [i*num_len +: num_len], slot 0 is the head.
REQ-014 SHALL have port snake_head, output, num_len, equal to slot 0.
REQ-015 SHALL have port len, output, max_len_bit_len, number of occupied slots minus 1.
REQ-016 SHALL have ports running, output, 1, and dead, output, 1, both decoded from the state.

Function
REQ-017 SHALL encode a cell as y*width+x; unused slots SHALL hold NONE = all ones, which never equals a valid cell.
REQ-018 SHALL implement states IDLE, RUN and DEAD.
- IDLE->RUN on start.
- RUN->DEAD on self-collision.
- DEAD->RUN on start, with re-initialisation.
REQ-019 SHALL load the initial layout on entry to RUN from DEAD.
- Slots 0..2 = (start_x,start_y), (start_x-1,start_y), (start_x-2,start_y); remaining slots NONE.
- len=2; direction right; pending grow cleared.
REQ-020 SHALL hold a pending direction register, updated every cycle from dir_in unless dir_in is the exact reverse of the committed direction; a reverse request is discarded.
REQ-021 SHALL, on tick in RUN, commit the pending direction and compute the new head one cell in that direction.
- Edges wrap: x=width-1 moving right goes to x=0; y=0 moving up goes to y=height-1; likewise for the other edges.
REQ-022 SHALL latch grow into a pending-grow flag; grow and tick in the same cycle SHALL apply to that tick.
REQ-023 SHALL, on a move, shift slot i-1 into slot i for all occupied slots and write the new head into slot 0.
- If pending grow is set and len<max_len-1: len increments, the old tail is kept, pending grow clears.
- Otherwise the tail slot becomes NONE and len is unchanged.
- Grow at len=max_len-1 saturates: flag clears, no length change.
REQ-024 SHALL detect self-collision when the new head equals any occupied slot except the departing tail.
- Growing move: compare against slots 0..len.
- Non-growing move: compare against slots 0..len-1.
REQ-025 SHALL, on collision, enter DEAD and leave snake, len and snake_head unchanged on that tick.
REQ-026 SHALL make all outputs registered; a tick at edge N appears on the outputs after edge N.
REQ-027 SHALL ignore tick and grow in IDLE and DEAD, and ignore start in RUN.

Reset
REQ-028 SHALL, on rst asserted asynchronously, immediately set state IDLE, running=0, dead=0, len=2, direction right, pending grow 0, and load the initial layout: slots 400, 399, 398, rest 1023.
REQ-029 SHALL keep every register at its reset value while rst is high, then resume on the first posedge after release; reset during RUN SHALL abort the game with no partial move.

Verification
REQ-030 SHALL cover: reset, start, tick with dir_in=3 -> snake_head=401, slots 1..2 = 400, 399, slot 3 = 1023, len=2.
REQ-031 SHALL cover: heading right, dir_in=2 then tick -> reverse ignored, head=401; dir_in=0 then tick -> head=401-32=369.
REQ-032 SHALL cover: head at 415 (x=31) moving right, tick -> head=384 (x=0, same row); head x=16 at y=0 moving up -> head=752.
REQ-033 SHALL cover: grow with tick in the same cycle -> len 2->3, tail 398 retained; 13 further grows -> len saturates at 15, slot 15 never NONE thereafter.
REQ-034 SHALL cover: five-slot snake steered up, left, down into its own neck -> dead=1, running=0, snake frozen; start -> initial layout restored, running=1.
REQ-035 SHALL cover: non-growing move into the cell just vacated by the tail -> no collision, running stays 1; rst mid-RUN -> outputs equal reset values within the same cycle.
